// File: rtl/pipeline_pkg.sv
// Shared definitions for the 8-bit pipelined core: datapath widths,
// write-back source encodings and the debug-write arbitration states.
package pipeline_pkg;

    localparam int PL_DW = 8;
    localparam int PL_AW = 2;

    // Encodings of wb_data_sel
    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_MEM = 1'b1;

    // Debug write arbitration states
    typedef enum logic [0:0] {
        DBG_IDLE = 1'b0,
        DBG_PEND = 1'b1
    } dbg_state_e;

endpackage

// File: rtl/pipeline_regfile.sv
// Architectural register file: 2**AW x DW entries, one synchronous write
// port, two combinational read ports, every entry reset to RST_VAL.
module pipeline_regfile
    import pipeline_pkg::*;
#(
    parameter int          DW      = PL_DW,
    parameter int          AW      = PL_AW,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] mem_r [2**AW];

    // Storage update; reset dominates so a write in the reset cycle is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem_r[i] <= RST_VAL;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata1 = mem_r[raddr1];
    assign rdata2 = mem_r[raddr2];

endmodule

// File: rtl/pipeline_wb.sv
// Write-back stage: selects write-back data, commits it to the register
// file, exposes bypassed read ports and an EX forwarding tap, and merges a
// debug register-write port into cycles the pipeline leaves free.
// Optional feature macro: PL_WB_RETIRE_CNT_EN (16-bit retired-slot counter).
module pipeline_wb
    import pipeline_pkg::*;
#(
    parameter int            DW      = PL_DW,
    parameter int            AW      = PL_AW,
    parameter logic [DW-1:0] RST_VAL = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] DM_in,
    input  logic [DW-1:0] ALU_ea_in,
    input  logic [AW-1:0] ra_in,
    input  logic          wb_wb_sel,
    input  logic          wb_data_sel,
    input  logic          wb_reg_en,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic [DW-1:0] rs1_data,
    output logic [DW-1:0] rs2_data,
    output logic          fwd_valid,
    output logic [AW-1:0] fwd_addr,
    output logic [DW-1:0] fwd_data,
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_data,
    output logic          dbg_ack,
    output logic [15:0]   retire_cnt
);

    logic [DW-1:0] wdata_s;
    logic          pc_we_s;

    dbg_state_e    state_r;
    dbg_state_e    state_nxt_s;
    logic [AW-1:0] pend_addr_r;
    logic [DW-1:0] pend_data_r;
    logic          pend_load_s;
    logic          dbg_ack_r;
    logic          dbg_commit_s;
    logic [AW-1:0] dbg_waddr_s;
    logic [DW-1:0] dbg_wdata_s;

    logic          rf_we_s;
    logic [AW-1:0] rf_waddr_s;
    logic [DW-1:0] rf_wdata_s;
    logic [DW-1:0] rf_rdata1_s;
    logic [DW-1:0] rf_rdata2_s;

    assign wdata_s = (wb_data_sel == WB_SRC_MEM) ? DM_in : ALU_ea_in;
    assign pc_we_s = wb_wb_sel & wb_reg_en;

    // Forwarding tap: zeroed whenever no pipeline commit happens
    always_comb begin
        fwd_valid = 1'b0;
        fwd_addr  = '0;
        fwd_data  = '0;
        if (pc_we_s) begin
            fwd_valid = 1'b1;
            fwd_addr  = ra_in;
            fwd_data  = wdata_s;
        end else begin
            fwd_valid = 1'b0;
        end
    end

    // Debug arbitration: the pipeline always wins, the debug write waits in
    // the pending buffer; a request still held during its ack cycle is ignored
    always_comb begin
        state_nxt_s  = state_r;
        pend_load_s  = 1'b0;
        dbg_commit_s = 1'b0;
        dbg_waddr_s  = pend_addr_r;
        dbg_wdata_s  = pend_data_r;
        case (state_r)
            DBG_IDLE: begin
                if (dbg_req && !dbg_ack_r) begin
                    if (pc_we_s) begin
                        pend_load_s = 1'b1;
                        state_nxt_s = DBG_PEND;
                    end else begin
                        dbg_commit_s = 1'b1;
                        dbg_waddr_s  = dbg_addr;
                        dbg_wdata_s  = dbg_data;
                    end
                end else begin
                    state_nxt_s = DBG_IDLE;
                end
            end
            DBG_PEND: begin
                if (!pc_we_s) begin
                    dbg_commit_s = 1'b1;
                    state_nxt_s  = DBG_IDLE;
                end else begin
                    state_nxt_s = DBG_PEND;
                end
            end
            default: begin
                state_nxt_s = DBG_IDLE;
            end
        endcase
    end

    // FSM state, pending buffer and the one-cycle ack pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= DBG_IDLE;
            pend_addr_r <= '0;
            pend_data_r <= '0;
            dbg_ack_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            dbg_ack_r <= dbg_commit_s;
            if (pend_load_s) begin
                pend_addr_r <= dbg_addr;
                pend_data_r <= dbg_data;
            end
        end
    end

    assign dbg_ack = dbg_ack_r;

    // Single register-file write port shared by pipeline and debug commits
    always_comb begin
        rf_we_s = pc_we_s | dbg_commit_s;
        if (pc_we_s) begin
            rf_waddr_s = ra_in;
            rf_wdata_s = wdata_s;
        end else begin
            rf_waddr_s = dbg_waddr_s;
            rf_wdata_s = dbg_wdata_s;
        end
    end

    pipeline_regfile #(
        .DW      (DW),
        .AW      (AW),
        .RST_VAL (RST_VAL)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (rf_we_s),
        .waddr  (rf_waddr_s),
        .wdata  (rf_wdata_s),
        .raddr1 (rs1_addr),
        .rdata1 (rf_rdata1_s),
        .raddr2 (rs2_addr),
        .rdata2 (rf_rdata2_s)
    );

    // Read port 1 bypass: pipeline commit first, then debug commit, then array
    always_comb begin
        if (pc_we_s && (rs1_addr == ra_in)) begin
            rs1_data = wdata_s;
        end else if (dbg_commit_s && (rs1_addr == dbg_waddr_s)) begin
            rs1_data = dbg_wdata_s;
        end else begin
            rs1_data = rf_rdata1_s;
        end
    end

    // Read port 2 bypass: same priority as port 1
    always_comb begin
        if (pc_we_s && (rs2_addr == ra_in)) begin
            rs2_data = wdata_s;
        end else if (dbg_commit_s && (rs2_addr == dbg_waddr_s)) begin
            rs2_data = dbg_wdata_s;
        end else begin
            rs2_data = rf_rdata2_s;
        end
    end

`ifdef PL_WB_RETIRE_CNT_EN
    logic [15:0] retire_cnt_r;

    // Retired-slot counter: every valid WB slot counts, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_r <= 16'h0000;
        end else if (wb_wb_sel) begin
            retire_cnt_r <= retire_cnt_r + 16'h0001;
        end
    end

    assign retire_cnt = retire_cnt_r;
`else
    assign retire_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_wb.sv
// Scoreboard bench for pipeline_wb: the stimulus process pushes the
// expected outputs for each driven cycle; a monitor pops and compares on
// the falling edge.
module tb_pipeline_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  DM_in, ALU_ea_in, dbg_data;
    logic [1:0]  ra_in, rs1_addr, rs2_addr, dbg_addr, fwd_addr;
    logic        wb_wb_sel, wb_data_sel, wb_reg_en, dbg_req;
    logic [7:0]  rs1_data, rs2_data, fwd_data;
    logic        fwd_valid, dbg_ack;
    logic [15:0] retire_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [15:0] exp_ret = 16'h0000;

    typedef struct {
        string       name;
        bit          c_rs1;
        logic [7:0]  rs1;
        bit          c_rs2;
        logic [7:0]  rs2;
        bit          c_fwd;
        logic        fv;
        logic [1:0]  fa;
        logic [7:0]  fd;
        bit          c_ack;
        logic        ack;
        logic [15:0] ret;
    } exp_t;

    exp_t sb_q[$];

    pipeline_wb dut (
        .clk(clk), .rst(rst), .DM_in(DM_in), .ALU_ea_in(ALU_ea_in),
        .ra_in(ra_in), .wb_wb_sel(wb_wb_sel), .wb_data_sel(wb_data_sel),
        .wb_reg_en(wb_reg_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .fwd_valid(fwd_valid),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data), .dbg_req(dbg_req),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ack(dbg_ack),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare whatever the stimulus queued for this cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.c_rs1) chk({e.name, ".rs1"}, {8'h00, rs1_data}, {8'h00, e.rs1});
            if (e.c_rs2) chk({e.name, ".rs2"}, {8'h00, rs2_data}, {8'h00, e.rs2});
            if (e.c_fwd) begin
                chk({e.name, ".fwd_valid"}, {15'h0, fwd_valid}, {15'h0, e.fv});
                chk({e.name, ".fwd_addr"}, {14'h0, fwd_addr}, {14'h0, e.fa});
                chk({e.name, ".fwd_data"}, {8'h00, fwd_data}, {8'h00, e.fd});
            end
            if (e.c_ack) chk({e.name, ".dbg_ack"}, {15'h0, dbg_ack}, {15'h0, e.ack});
            chk({e.name, ".retire_cnt"}, retire_cnt, e.ret);
        end
    end

    task automatic expect_cyc(input string name,
                              input bit c_rs1, input logic [7:0] rs1,
                              input bit c_rs2, input logic [7:0] rs2,
                              input bit c_fwd, input logic fv, input logic [1:0] fa,
                              input logic [7:0] fd, input bit c_ack, input logic ack);
        exp_t e;
        e.name = name; e.c_rs1 = c_rs1; e.rs1 = rs1; e.c_rs2 = c_rs2; e.rs2 = rs2;
        e.c_fwd = c_fwd; e.fv = fv; e.fa = fa; e.fd = fd;
        e.c_ack = c_ack; e.ack = ack; e.ret = exp_ret;
        sb_q.push_back(e);
    endtask

    // Advance one clock; retire model follows the edge, then step off it
    task automatic cyc();
        @(posedge clk);
`ifdef PL_WB_RETIRE_CNT_EN
        if (rst) exp_ret = 16'h0000;
        else if (wb_wb_sel) exp_ret = exp_ret + 16'h0001;
`endif
        #1;
    endtask

    task automatic wb(input logic sel, input logic en, input logic dsel,
                      input logic [7:0] dm, input logic [7:0] alu, input logic [1:0] ra);
        wb_wb_sel = sel; wb_reg_en = en; wb_data_sel = dsel;
        DM_in = dm; ALU_ea_in = alu; ra_in = ra;
    endtask

    initial begin
        rst = 1'b1; dbg_req = 1'b0; dbg_addr = 2'd0; dbg_data = 8'h00;
        rs1_addr = 2'd0; rs2_addr = 2'd0;
        wb(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
        cyc(); cyc();
        rst = 1'b0;

        // Reset state of the array and outputs
        rs1_addr = 2'd0; rs2_addr = 2'd1;
        expect_cyc("rst_r0r1", 1, 8'h00, 1, 8'h00, 1, 0, 2'd0, 8'h00, 1, 0); cyc();
        rs1_addr = 2'd2; rs2_addr = 2'd3;
        expect_cyc("rst_r2r3", 1, 8'h00, 1, 8'h00, 1, 0, 2'd0, 8'h00, 1, 0); cyc();

        // Memory-sourced commit with same-cycle bypass, then from the array
        wb(1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C, 2'd2); rs1_addr = 2'd2; rs2_addr = 2'd0;
        expect_cyc("mem_wb", 1, 8'hA5, 1, 8'h00, 1, 1, 2'd2, 8'hA5, 1, 0); cyc();
        wb(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 2'd0);
        expect_cyc("mem_arr", 1, 8'hA5, 0, 8'h00, 1, 0, 2'd0, 8'h00, 0, 0); cyc();
        // ALU-sourced commit to the same register
        wb(1'b1, 1'b1, 1'b0, 8'hA5, 8'h3C, 2'd2);
        expect_cyc("alu_wb", 1, 8'h3C, 0, 8'h00, 1, 1, 2'd2, 8'h3C, 0, 0); cyc();
        wb(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
        expect_cyc("alu_arr", 1, 8'h3C, 0, 8'h00, 1, 0, 2'd0, 8'h00, 0, 0); cyc();

        // Bubble with reg_en set must not write
        wb(1'b0, 1'b1, 1'b0, 8'h00, 8'h77, 2'd1); rs1_addr = 2'd1;
        expect_cyc("bubble", 1, 8'h00, 0, 8'h00, 1, 0, 2'd0, 8'h00, 0, 0); cyc();
        wb(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
        expect_cyc("bubble_arr", 1, 8'h00, 0, 8'h00, 1, 0, 2'd0, 8'h00, 0, 0); cyc();

        // Debug write to r3 held off by three pipeline commits to r1
        dbg_req = 1'b1; dbg_addr = 2'd3; dbg_data = 8'h5A; rs1_addr = 2'd3; rs2_addr = 2'd1;
        wb(1'b1, 1'b1, 1'b0, 8'h00, 8'h11, 2'd1);
        expect_cyc("pend1", 1, 8'h00, 1, 8'h11, 1, 1, 2'd1, 8'h11, 1, 0); cyc();
        wb(1'b1, 1'b1, 1'b0, 8'h00, 8'h22, 2'd1);
        expect_cyc("pend2", 1, 8'h00, 1, 8'h22, 1, 1, 2'd1, 8'h22, 1, 0); cyc();
        wb(1'b1, 1'b1, 1'b0, 8'h00, 8'h33, 2'd1);
        expect_cyc("pend3", 1, 8'h00, 1, 8'h33, 1, 1, 2'd1, 8'h33, 1, 0); cyc();
        wb(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
        expect_cyc("pend_commit", 1, 8'h5A, 1, 8'h33, 1, 0, 2'd0, 8'h00, 1, 0); cyc();
        // Request still high in the ack cycle with new data: must be ignored
        dbg_data = 8'hC3;
        expect_cyc("pend_ack", 1, 8'h5A, 1, 8'h33, 0, 0, 2'd0, 8'h00, 1, 1); cyc();
        dbg_req = 1'b0;
        expect_cyc("pend_after", 1, 8'h5A, 1, 8'h33, 0, 0, 2'd0, 8'h00, 1, 0); cyc();

        // Immediate debug write on a free cycle
        dbg_req = 1'b1; dbg_addr = 2'd0; dbg_data = 8'h9C; rs1_addr = 2'd0;
        expect_cyc("idle_dbg", 1, 8'h9C, 0, 8'h00, 0, 0, 2'd0, 8'h00, 1, 0); cyc();
        dbg_req = 1'b0;
        expect_cyc("idle_ack", 1, 8'h9C, 0, 8'h00, 0, 0, 2'd0, 8'h00, 1, 1); cyc();
        expect_cyc("idle_after", 1, 8'h9C, 0, 8'h00, 0, 0, 2'd0, 8'h00, 1, 0); cyc();

        // Pending debug write discarded by reset; write in reset cycle dropped
        dbg_req = 1'b1; dbg_addr = 2'd3; dbg_data = 8'h44; rs1_addr = 2'd3;
        wb(1'b1, 1'b1, 1'b0, 8'h00, 8'h55, 2'd1);
        expect_cyc("rst_pend", 1, 8'h5A, 0, 8'h00, 0, 0, 2'd0, 8'h00, 1, 0); cyc();
        dbg_req = 1'b0; rst = 1'b1;
        wb(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0); cyc();
        wb(1'b1, 1'b1, 1'b1, 8'hEE, 8'h00, 2'd2); cyc();
        rst = 1'b0; wb(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0); rs2_addr = 2'd2;
        expect_cyc("post_rst", 1, 8'h00, 1, 8'h00, 1, 0, 2'd0, 8'h00, 1, 0); cyc();
        rs2_addr = 2'd1;
        expect_cyc("post_rst2", 1, 8'h00, 1, 8'h00, 0, 0, 2'd0, 8'h00, 1, 0); cyc();

`ifdef PL_WB_RETIRE_CNT_EN
        // Run the counter up to its wrap point with non-writing valid slots
        wb(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
        while (exp_ret != 16'hFFFF) cyc();
        expect_cyc("ret_max", 0, 8'h00, 0, 8'h00, 0, 0, 2'd0, 8'h00, 0, 0); cyc();
        wb(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
        expect_cyc("ret_wrap", 0, 8'h00, 0, 8'h00, 0, 0, 2'd0, 8'h00, 0, 0); cyc();
        chk("ret_wrap_model", exp_ret, 16'h0000);
`endif

        cyc(); cyc();
        chk("sb_drained", 16'(sb_q.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipeline_wb.md
Name: pipeline_wb

Overview:
- Write-back stage of the 8-bit pipelined core; consumes the MEM/WB pipeline register outputs.
- Selects write-back data (memory vs ALU), commits it to the 4x8 architectural register file, and provides read ports with write-through bypass plus an EX forwarding tap.
- Arbitrates a debug register-write port against pipeline commits using a one-entry pending buffer and an ack handshake.

Parameters:
- DW, 8, data/register width
- AW, 2, register address width (2**AW registers)
- RST_VAL, 8'h00, reset value of every register-file entry

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- DM_in  in  DW  load data from MEM/WB register
- ALU_ea_in  in  DW  ALU result / effective address from MEM/WB register
- ra_in  in  AW  destination register
- wb_wb_sel  in  1  WB slot valid; 0 = bubble
- wb_data_sel  in  1  1 = write DM_in, 0 = write ALU_ea_in
- wb_reg_en  in  1  register write enable
- rs1_addr, rs2_addr  in  AW  read addresses
- rs1_data, rs2_data  out  DW  read data, combinational, with bypass
- fwd_valid  out  1  a pipeline commit occurs this cycle
- fwd_addr  out  AW  commit address
- fwd_data  out  DW  commit data
- dbg_req  in  1  debug write request; held until ack
- dbg_addr  in  AW  debug write address
- dbg_data  in  DW  debug write data
- dbg_ack  out  1  one-cycle pulse when the debug write commits
- retire_cnt  out  16  retired WB-slot count (optional feature)

Behaviour:
- wdata = wb_data_sel ? DM_in : ALU_ea_in.
- Pipeline commit: pc_we = wb_wb_sel & wb_reg_en. It writes wdata to reg[ra_in] at the posedge; no stall path, latency 0.
- fwd_valid = pc_we, fwd_addr = ra_in, fwd_data = wdata. All combinational; all 0 when pc_we = 0.
- Read bypass:
  - rsN_data = wdata if pc_we and rsN_addr == ra_in.
  - Otherwise, if a debug commit is occurring this cycle to rsN_addr, the debug data.
  - Otherwise reg[rsN_addr].
- Debug FSM, states IDLE, PEND:
  - IDLE, dbg_req=1, pc_we=0: write dbg_data to reg[dbg_addr] this cycle; dbg_ack=1 on the next cycle; stay IDLE.
  - IDLE, dbg_req=1, pc_we=1: latch dbg_addr/dbg_data into the pending buffer; go to PEND.
  - PEND, pc_we=0: commit the buffered write; go to IDLE; dbg_ack=1 next cycle.
  - PEND, pc_we=1: stay in PEND; the pipeline always wins.
- dbg_ack is registered and high for exactly one cycle per accepted request.
- Requester deasserts dbg_req in the ack cycle. A dbg_req still high in the ack cycle is ignored (no double write); a new request is accepted from the following cycle.
- Pipeline and debug commits to the same address can never coincide, because the pipeline has priority.
- Bubble (wb_wb_sel=0): no write regardless of wb_reg_en; it does not count as retired.
- Reset:
  - All registers = RST_VAL; FSM = IDLE; pending buffer cleared.
  - dbg_ack=0, retire_cnt=0.
  - A write presented in the reset cycle is dropped. A pending debug write at reset is discarded with no ack.

Optional Feature:
- Macro: PL_WB_RETIRE_CNT_EN.
- Defined: 16-bit retire_cnt increments on every cycle with wb_wb_sel=1, including non-writing instructions. It wraps from 16'hFFFF to 0 and is cleared by rst.
- Undefined: retire_cnt is tied to 0; no counter flops are present.

Decomposition:
- Shared package pipeline_pkg holds:
  - DW/AW constants.
  - Encodings WB_SRC_ALU=0 and WB_SRC_MEM=1 for wb_data_sel.
  - Debug FSM state enum (IDLE, PEND).
- One sub-module, pipeline_regfile: 2**AW x DW storage, one write port, two combinational read ports, reset to RST_VAL. Bypass and arbitration stay in pipeline_wb.

Test Plan:
- Reset, then read r0..r3 -> all 8'h00; dbg_ack=0; retire_cnt=0.
- wb_wb_sel=1, wb_reg_en=1, wb_data_sel=1, DM_in=8'hA5, ALU_ea_in=8'h3C, ra_in=2, rs1_addr=2 -> same cycle: rs1_data=8'hA5, fwd_valid=1, fwd_addr=2, fwd_data=8'hA5. Next cycle with a bubble -> rs1_data=8'hA5 from the array. Repeat with wb_data_sel=0 -> rs1_data=8'h3C.
- wb_reg_en=1, wb_wb_sel=0, ra_in=1, ALU_ea_in=8'h77 -> r1 unchanged (8'h00); fwd_valid=0; retire_cnt unchanged.
- dbg_req to r3=8'h5A during 3 consecutive pipeline commits to r1 -> FSM stays PEND; r3 written in the first free cycle; dbg_ack pulses once on the cycle after; r1 holds the last pipeline value.
- Debug write pending, rst asserted -> r3 stays 8'h00; no dbg_ack; FSM IDLE.
- PL_WB_RETIRE_CNT_EN defined: preload via 65535 valid slots, then 1 more -> retire_cnt 16'hFFFF then 16'h0000. Undefined: retire_cnt stays 0.
